spi_mem_arbiter: RTL and testbench
==================================

SPI_MEM_ARBITER -- requirements
Module: spi_mem_arbiter

Interface
REQ-001 SHALL have parameter CMD_READ, default 8'h03, SPI read opcode.
REQ-002 SHALL have parameter CMD_WRITE, default 8'h02, SPI write opcode.
REQ-003 SHALL have ports:
- clk  input  1  sole clock; every flop is clocked on the rising edge.
- rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have instruction-fetch ports:
- if_req  input  1  fetch request.
- if_addr  input  24  byte address.
- if_rdata  output  32  fetched word.
- if_ack  output  1  one-cycle completion pulse.
REQ-005 SHALL have data-memory ports:
- dm_req  input  1  load/store request.
- dm_we  input  1  1 = store, 0 = load.
- dm_addr  input  24  byte address.
- dm_wdata  input  32  store data.
- dm_rdata  output  32  load data.
- dm_ack  output  1  one-cycle completion pulse.
REQ-006 SHALL have SPI master ports:
- spi_cs_n  output  1  chip select, active-low.
- spi_sclk  output  1  serial clock, mode 0.
- spi_mosi  output  1  serial data out.
- spi_miso  input  1  serial data in.

Function
REQ-007 SHALL implement states IDLE, SHIFT and DONE.
REQ-008 In IDLE, with any request high, SHALL grant one requester, latch its address, write-enable and write data, and enter SHIFT on the next cycle.
REQ-009 SHALL grant by round-robin arbitration:
- One requester pending: grant it.
- Both pending: grant the requester that was not granted last.
- Out of reset, last-granted = if, so dm wins the first tie.
REQ-010 Every frame SHALL be 64 bits, MSB first:
- 8-bit opcode: CMD_WRITE if dm_we on a dm grant, else CMD_READ.
- 24-bit address with bits [1:0] forced to 0.
- 32 data bits.
REQ-011 SHALL generate spi_sclk at clk/2:
- Each bit lasts 2 cycles: a low phase, then a high phase.
- spi_mosi changes only at the start of a low phase.
- spi_miso is sampled on the clk edge that ends the high phase.
REQ-012 spi_cs_n SHALL be low for exactly 128 cycles per frame; spi_sclk SHALL be low whenever spi_cs_n is high.
REQ-013 On reads, SHALL drive spi_mosi low during the 32 data bits; the first data bit received SHALL land in rdata[31].
REQ-014 On writes, SHALL shift out the latched wdata[31:0] MSB first; rdata of that requester is left unchanged.
REQ-015 Latency from a request sampled high in IDLE (cycle 0):
- spi_cs_n low in cycles 1..128.
- DONE in cycle 129, with spi_cs_n high and the granted ack high for exactly that cycle.
- rdata valid from cycle 129 and held until that requester's next read completes.
REQ-016 After DONE, SHALL return to IDLE for at least 1 cycle, guaranteeing a minimum of 2 cycles with spi_cs_n high between frames.
REQ-017 A requester SHALL hold req, addr, we and wdata stable until its ack; the block only samples them at grant.
REQ-018 A req held high in the cycle after its ack SHALL be treated as a new request.
REQ-019 A req dropped before grant SHALL not be served.
REQ-020 A req dropped after grant SHALL not abort the frame; the ack is still pulsed.
REQ-021 if_ack and dm_ack SHALL never be high in the same cycle; no ack SHALL occur outside DONE.
REQ-022 A requester not granted SHALL see no change on its rdata or ack.

Reset
REQ-023 While rst is high, on the next clk edge the block SHALL reach this state:
- state IDLE.
- spi_cs_n = 1, spi_sclk = 0, spi_mosi = 0.
- if_ack = dm_ack = 0.
- if_rdata = dm_rdata = 32'h0.
- last-granted = if.
REQ-024 Reset asserted mid-frame SHALL abort the frame with no ack, and spi_cs_n SHALL be high the cycle after the reset edge.
REQ-025 After rst deasserts, the first grant SHALL be possible in the first cycle with rst low.

Verification
REQ-026 Fetch read:
- Stimulus: if_req with if_addr = 24'h000104; SPI model returns 32'hDEADBEEF.
- Response: MOSI carries 8'h03 then 24'h000104; if_rdata = 32'hDEADBEEF with if_ack in cycle 129.
REQ-027 Store:
- Stimulus: dm_req, dm_we = 1, dm_addr = 24'h00200B, dm_wdata = 32'h12345678.
- Response: MOSI carries 8'h02, 24'h002008, 32'h12345678; dm_ack pulses once; dm_rdata unchanged.
REQ-028 Simultaneous requests:
- Stimulus: if_req and dm_req rise together out of reset and both stay high.
- Response: grants go dm, if, dm, if; exactly one ack per frame; at least 2 cs_n-high cycles between frames.
REQ-029 Dropped request:
- Stimulus: dm_req drops 10 cycles into its frame.
- Response: the frame completes its 128 cycles and dm_ack still pulses.
- Stimulus: a req pulse shorter than one cycle, given while a frame is in progress.
- Response: never served.
REQ-030 Reset mid-frame:
- Stimulus: rst high at frame cycle 60.
- Response: spi_cs_n = 1 and spi_sclk = 0 next cycle; no ack; a request after reset runs a full 64-bit frame.

Source files
------------

// File: rtl/spi_mem_arbiter.sv
// spi_mem_arbiter
//   Shares one SPI memory between an instruction-fetch port and a data-memory
//   port. Each granted access runs one 64-bit mode-0 frame:
//   opcode[7:0], word-aligned address[23:0], data[31:0], all MSB first.
//   spi_sclk runs at clk/2, and each bit is a low phase followed by a high phase.
//   Ties between the two ports are broken round-robin.
//
// Ports
//   clk, rst        : rising-edge clock, synchronous active-high reset
//   if_req/if_addr  : fetch request and byte address
//   if_rdata/if_ack : fetched word, one-cycle completion pulse
//   dm_req/dm_we/dm_addr/dm_wdata : load/store request, store data
//   dm_rdata/dm_ack : load data, one-cycle completion pulse
//   spi_cs_n/spi_sclk/spi_mosi/spi_miso : SPI master pins
module spi_mem_arbiter #(
   parameter logic [7:0] CMD_READ  = 8'h03,
   parameter logic [7:0] CMD_WRITE = 8'h02
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [23:0] if_addr,
   output logic [31:0] if_rdata,
   output logic        if_ack,
   input  logic        dm_req,
   input  logic        dm_we,
   input  logic [23:0] dm_addr,
   input  logic [31:0] dm_wdata,
   output logic [31:0] dm_rdata,
   output logic        dm_ack,
   output logic        spi_cs_n,
   output logic        spi_sclk,
   output logic        spi_mosi,
   input  logic        spi_miso
);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t      state, state_nxt;
   logic [6:0]  cnt, cnt_nxt;        // [6:1] bit index, [0] clock phase
   logic [63:0] sh, sh_nxt;          // outgoing frame, MSB on the wire
   logic [31:0] rx, rx_nxt;          // last 32 bits sampled from miso
   logic        gnt_dm, gnt_dm_nxt;
   logic        wr, wr_nxt;
   logic        last_if, last_if_nxt;
   logic [31:0] if_rdata_nxt, dm_rdata_nxt;
   logic        if_ack_nxt, dm_ack_nxt;
   logic        cs_n_nxt, sclk_nxt, mosi_nxt;
   logic        pick_dm;
   logic        pick_wr;
   logic [23:0] addr_sel;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         sh       <= '0;
         rx       <= '0;
         gnt_dm   <= 1'b0;
         wr       <= 1'b0;
         last_if  <= 1'b1;
         if_rdata <= '0;
         dm_rdata <= '0;
         if_ack   <= 1'b0;
         dm_ack   <= 1'b0;
         spi_cs_n <= 1'b1;
         spi_sclk <= 1'b0;
         spi_mosi <= 1'b0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         sh       <= sh_nxt;
         rx       <= rx_nxt;
         gnt_dm   <= gnt_dm_nxt;
         wr       <= wr_nxt;
         last_if  <= last_if_nxt;
         if_rdata <= if_rdata_nxt;
         dm_rdata <= dm_rdata_nxt;
         if_ack   <= if_ack_nxt;
         dm_ack   <= dm_ack_nxt;
         spi_cs_n <= cs_n_nxt;
         spi_sclk <= sclk_nxt;
         spi_mosi <= mosi_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      cnt_nxt      = cnt;
      sh_nxt       = sh;
      rx_nxt       = rx;
      gnt_dm_nxt   = gnt_dm;
      wr_nxt       = wr;
      last_if_nxt  = last_if;
      if_rdata_nxt = if_rdata;
      dm_rdata_nxt = dm_rdata;

      // dm wins when it is alone or when fetch had the previous grant
      pick_dm  = dm_req && (!if_req || last_if);
      pick_wr  = pick_dm && dm_we;
      addr_sel = (pick_dm ? dm_addr : if_addr) & ~24'h000003;

      case (state)
         IDLE: begin
            if (if_req || dm_req) begin
               state_nxt   = SHIFT;
               cnt_nxt     = '0;
               gnt_dm_nxt  = pick_dm;
               wr_nxt      = pick_wr;
               last_if_nxt = !pick_dm;
               sh_nxt      = {pick_wr ? CMD_WRITE : CMD_READ, addr_sel,
                              pick_wr ? dm_wdata : 32'h0};
            end
         end
         SHIFT: begin
            cnt_nxt = cnt + 7'd1;
            // end of a high phase: sample miso, advance mosi into the next low phase
            if (cnt[0]) begin
               sh_nxt = {sh[62:0], 1'b0};
               rx_nxt = {rx[30:0], spi_miso};
               if (cnt == 7'd127) begin
                  state_nxt = DONE;
                  if (!wr) begin
                     if (gnt_dm) dm_rdata_nxt = rx_nxt;
                     else        if_rdata_nxt = rx_nxt;
                  end
               end
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase

      // Pin and ack values are decoded from the next state so they leave flops
      cs_n_nxt   = (state_nxt != SHIFT);
      sclk_nxt   = (state_nxt == SHIFT) && cnt_nxt[0];
      mosi_nxt   = (state_nxt == SHIFT) && sh_nxt[63];
      if_ack_nxt = (state_nxt == DONE) && !gnt_dm_nxt;
      dm_ack_nxt = (state_nxt == DONE) && gnt_dm_nxt;
   end

endmodule

// File: tb/tb_spi_mem_arbiter.sv
// Directed bench for spi_mem_arbiter with an SPI slave model and scoreboards
// for expected frames (MOSI content, MISO response) and expected acks.
module tb_spi_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req, dm_req, dm_we;
   logic [23:0] if_addr, dm_addr;
   logic [31:0] dm_wdata;
   logic [31:0] if_rdata, dm_rdata;
   logic        if_ack, dm_ack;
   logic        spi_cs_n, spi_sclk, spi_mosi;
   logic        spi_miso;

   spi_mem_arbiter #(.CMD_READ(8'h03), .CMD_WRITE(8'h02)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_rdata(dm_rdata), .dm_ack(dm_ack),
      .spi_cs_n(spi_cs_n), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi),
      .spi_miso(spi_miso)
   );

   always #5 clk = ~clk;

   typedef struct { logic [63:0] frame; logic [63:0] resp; } frame_t;
   typedef struct { logic dm; logic [31:0] if_rd; logic [31:0] dm_rd; } ack_t;

   frame_t fq[$];
   ack_t   aq[$];
   int     errors = 0;
   int     checks = 0;
   int     frames_started = 0;
   int     ack_count = 0;
   logic   abort_pending = 1'b0;
   logic [31:0] exp_if = '0;
   logic [31:0] exp_dm = '0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Slave model + ack scoreboard, sampled on the falling clk edge
   task automatic monitor();
      logic        in_frame = 1'b0;
      int          low_cnt = 0, nbits = 0, gap_cnt = 0;
      logic [63:0] cap = '0;
      logic        mosi_low = 1'b0;
      frame_t      cur = '{frame: '0, resp: '0};
      ack_t        a;
      forever begin
         @(negedge clk);
         if (spi_cs_n === 1'b0) begin
            if (!in_frame) begin
               in_frame = 1'b1; low_cnt = 0; nbits = 0; cap = '0;
               if (frames_started > 0) chk("cs_gap_ge2", 64'(gap_cnt >= 2), 64'd1);
               frames_started++;
               chk("frame_expected", 64'(fq.size() != 0), 64'd1);
               if (fq.size() != 0) cur = fq.pop_front();
            end
            low_cnt++;
            if (spi_sclk) begin
               chk("mosi_stable", 64'(spi_mosi), 64'(mosi_low));
               cap = {cap[62:0], spi_mosi};
               nbits++;
            end else begin
               mosi_low = spi_mosi;
               if (nbits < 64) spi_miso = cur.resp[63 - nbits];
            end
         end else begin
            chk("sclk_idle", 64'(spi_sclk), 64'd0);
            if (in_frame) begin
               in_frame = 1'b0; gap_cnt = 0;
               if (abort_pending) abort_pending = 1'b0;
               else begin
                  chk("cs_low_cycles", 64'(low_cnt), 64'd128);
                  chk("mosi_frame", cap, cur.frame);
               end
            end
            gap_cnt++;
            spi_miso = 1'b0;
         end
         if (if_ack || dm_ack) begin
            chk("ack_exclusive", 64'(if_ack & dm_ack), 64'd0);
            chk("ack_cs_high", 64'(spi_cs_n), 64'd1);
            chk("ack_expected", 64'(aq.size() != 0), 64'd1);
            if (aq.size() != 0) begin
               a = aq.pop_front();
               chk("ack_owner_dm", 64'(dm_ack), 64'(a.dm));
               chk("if_rdata", 64'(if_rdata), 64'(a.if_rd));
               chk("dm_rdata", 64'(dm_rdata), 64'(a.dm_rd));
            end
            ack_count++;
         end
      end
   endtask

   function automatic frame_t mk_frame(input logic wr_op, input logic [23:0] addr,
                                       input logic [31:0] wdata, input logic [31:0] rword);
      frame_t f;
      f.frame = {wr_op ? 8'h02 : 8'h03, addr[23:2], 2'b00, wr_op ? wdata : 32'h0};
      f.resp  = {$urandom(), rword};
      return f;
   endfunction

   // Expected results are queued, then the request is driven; called at posedge+1
   task automatic do_req(input logic dm, input logic we, input logic [23:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rword,
                         input int drop_at, input int glitch_at);
      int n;
      fq.push_back(mk_frame(dm && we, addr, wdata, rword));
      if (!(dm && we)) begin
         if (dm) exp_dm = rword; else exp_if = rword;
      end
      aq.push_back('{dm: dm, if_rd: exp_if, dm_rd: exp_dm});
      if (dm) begin dm_req = 1'b1; dm_we = we; dm_addr = addr; dm_wdata = wdata; end
      else begin if_req = 1'b1; if_addr = addr; end
      n = 0;
      while (n < 300) begin
         @(negedge clk);
         if (dm ? dm_ack : if_ack) break;
         if (n == drop_at) begin if (dm) dm_req = 1'b0; else if_req = 1'b0; end
         if (n == glitch_at) begin
            if (dm) begin if_req = 1'b1; #1 if_req = 1'b0; end
            else begin dm_req = 1'b1; #1 dm_req = 1'b0; end
         end
         n++;
      end
      chk("ack_latency", 64'(n), 64'd129);
      @(posedge clk); #1;
      if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_cs_n"},     64'(spi_cs_n), 64'd1);
      chk({tag, "_sclk"},     64'(spi_sclk), 64'd0);
      chk({tag, "_mosi"},     64'(spi_mosi), 64'd0);
      chk({tag, "_if_ack"},   64'(if_ack),   64'd0);
      chk({tag, "_dm_ack"},   64'(dm_ack),   64'd0);
      chk({tag, "_if_rdata"}, 64'(if_rdata), 64'd0);
      chk({tag, "_dm_rdata"}, 64'(dm_rdata), 64'd0);
   endtask

   initial begin
      int target;
      rst = 1'b1; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
      if_addr = '0; dm_addr = '0; dm_wdata = '0; spi_miso = 1'b0;
      fork
         monitor();
      join_none

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_reset_state("reset");
      @(posedge clk); #1 rst = 1'b0;

      // fetch read, then a load so dm_rdata is non-zero before the store
      do_req(1'b0, 1'b0, 24'h000104, 32'h0, 32'hDEADBEEF, -1, -1);
      do_req(1'b1, 1'b0, 24'h000040, 32'h0, 32'hCAFEF00D, -1, -1);
      do_req(1'b1, 1'b1, 24'h00200B, 32'h12345678, 32'h0BADF00D, -1, -1);
      // load whose req drops at frame cycle 10, with a short if_req glitch mid-frame
      do_req(1'b1, 1'b0, 24'h000300, 32'h0, 32'h76543210, 10, 50);
      repeat (20) @(posedge clk);
      chk("frames_after_glitch", 64'(frames_started), 64'd4);
      chk("acks_after_glitch",   64'(ack_count),      64'd4);

      // both requesters rise together in the first cycle after reset
      #1 rst = 1'b1;
      repeat (2) @(posedge clk);
      exp_if = '0; exp_dm = '0;
      for (int k = 0; k < 4; k++) begin
         logic        kdm;
         logic [31:0] w;
         kdm = (k % 2 == 0);
         w   = 32'h1111_1111 * (k + 1);
         fq.push_back(mk_frame(1'b0, kdm ? 24'h000020 : 24'h000010, 32'h0, w));
         if (kdm) exp_dm = w; else exp_if = w;
         aq.push_back('{dm: kdm, if_rd: exp_if, dm_rd: exp_dm});
      end
      target = ack_count + 4;
      #1;
      rst = 1'b0; if_req = 1'b1; if_addr = 24'h000010;
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 24'h000020;
      for (int c = 0; c < 1000 && ack_count < target; c++) @(posedge clk);
      chk("tie_ack_count", 64'(ack_count), 64'(target));
      #1 if_req = 1'b0; dm_req = 1'b0;
      repeat (10) @(posedge clk);
      chk("frames_after_tie", 64'(frames_started), 64'd8);
      #1;

      // reset at frame cycle 60
      fq.push_back(mk_frame(1'b0, 24'h000080, 32'h0, 32'h55AA55AA));
      if_req = 1'b1; if_addr = 24'h000080;
      repeat (61) @(negedge clk);
      abort_pending = 1'b1; rst = 1'b1; if_req = 1'b0;
      @(negedge clk);
      chk_reset_state("abort");
      exp_if = '0; exp_dm = '0;
      @(posedge clk); #1 rst = 1'b0;
      repeat (5) @(posedge clk);
      chk("acks_after_abort", 64'(ack_count), 64'd8);
      #1;
      do_req(1'b1, 1'b1, 24'h0000F0, 32'hA5A55A5A, 32'h13572468, -1, -1);
      do_req(1'b0, 1'b0, 24'hFFFFFF, 32'h0, 32'h89ABCDEF, -1, -1);

      repeat (5) @(posedge clk);
      chk("frames_total",  64'(frames_started), 64'd11);
      chk("acks_total",    64'(ack_count),      64'd10);
      chk("frame_q_empty", 64'(fq.size()),      64'd0);
      chk("ack_q_empty",   64'(aq.size()),      64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
